// File: rtl/perf_event_counter.sv
// Performance-monitor counter block: one elapsed-cycle counter plus
// NUM_EVENTS per-cycle event counters with run/pause/freeze/done control,
// an optional cycle limit, wrap or saturate overflow and a registered read port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | not counting; start_i high moves to RUN
// RUN    | counting on every edge with start_i high
// FROZEN | counters hold; freeze_i leaves to RUN or IDLE
// DONE   | cycle limit reached; only clear_i or rst_i leave
module perf_event_counter #(
  parameter int              NUM_EVENTS  = 4,
  parameter int              CNT_WIDTH   = 32,
  parameter bit              SATURATE    = 1'b1,
  parameter longint unsigned CYCLE_LIMIT = 0,
  parameter int              SEL_W       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  clear_i,
  input  logic                  freeze_i,
  input  logic                  rd_req_i,
  input  logic [SEL_W-1:0]      rd_sel_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic                  rd_valid_o,
  output logic [NUM_EVENTS:0]   ovf_o,
  output logic                  done_o,
  output logic [1:0]            state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FROZEN = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

  // A limit that does not fit in the counter can never be reached.
  localparam bit LIMIT_EN = (CYCLE_LIMIT != 0) &&
                            ((CNT_WIDTH >= 64) || (CYCLE_LIMIT < (64'd1 << CNT_WIDTH)));
  localparam logic [CNT_WIDTH-1:0] LIMIT_VAL = CYCLE_LIMIT[CNT_WIDTH-1:0];

  // Index 0 is the cycle counter, index k+1 is event counter k.
  logic [NUM_EVENTS:0][CNT_WIDTH-1:0] cnt;
  logic [NUM_EVENTS:0][CNT_WIDTH-1:0] cnt_bump;
  logic [NUM_EVENTS:0]                at_max;
  logic [NUM_EVENTS:0]                inc;
  logic [CNT_WIDTH-1:0]               rd_mux;
  logic                               limit_hit;

  // Next value of each counter if it were incremented this edge.
  always_comb begin
    cnt_bump = '0;
    at_max   = '0;
    for (int j = 0; j <= NUM_EVENTS; j++) begin
      at_max[j]   = (cnt[j] == ALL_ONES);
      cnt_bump[j] = at_max[j] ? (SATURATE ? ALL_ONES : '0) : cnt[j] + CNT_WIDTH'(1);
    end
    inc       = {event_i, 1'b1};
    limit_hit = LIMIT_EN && !at_max[0] && (cnt_bump[0] == LIMIT_VAL);
  end

  // Read-select mux over the current (pre-increment) counter values.
  always_comb begin
    rd_mux = '0;
    for (int j = 0; j <= NUM_EVENTS; j++) begin
      if (rd_sel_i == SEL_W'(j)) rd_mux = cnt[j];
    end
  end

  // Control state, counters, sticky flags and the registered read port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt        <= '0;
      ovf_o      <= '0;
      done_o     <= 1'b0;
      state_o    <= S_IDLE;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i) rd_data_o <= rd_mux;

      if (clear_i) begin
        cnt     <= '0;
        ovf_o   <= '0;
        done_o  <= 1'b0;
        state_o <= S_IDLE;
      end else begin
        case (state_o)
          S_IDLE: begin
            if (start_i) state_o <= S_RUN;
          end
          S_RUN: begin
            if (freeze_i) begin
              state_o <= S_FROZEN;
            end else if (!start_i) begin
              state_o <= S_IDLE;
            end else begin
              for (int j = 0; j <= NUM_EVENTS; j++) begin
                if (inc[j]) begin
                  cnt[j] <= cnt_bump[j];
                  if (at_max[j]) ovf_o[j] <= 1'b1;
                end
              end
              if (limit_hit) begin
                state_o <= S_DONE;
                done_o  <= 1'b1;
              end
            end
          end
          S_FROZEN: begin
            if (freeze_i) state_o <= start_i ? S_RUN : S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_perf_event_counter.sv
// Bench for perf_event_counter: three 8-bit instances (saturate, wrap,
// saturate with a 100-cycle limit) share one stimulus stream and are
// checked every cycle against a counter-array model, plus literal checks.
module tb_perf_event_counter;

  localparam int NE = 4;
  localparam int W  = 8;
  localparam int MAXV = 255;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, clear = 1'b0, freeze = 1'b0, rd_req = 1'b0;
  logic [NE-1:0] ev = '0;
  logic [3:0] sel = '0;

  logic [W-1:0]  rd_data [3];
  logic          rd_valid[3];
  logic [NE:0]   ovf     [3];
  logic          done    [3];
  logic [1:0]    state   [3];

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  perf_event_counter #(.NUM_EVENTS(NE), .CNT_WIDTH(W), .SATURATE(1'b1), .CYCLE_LIMIT(0), .SEL_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .event_i(ev), .clear_i(clear), .freeze_i(freeze),
    .rd_req_i(rd_req), .rd_sel_i(sel), .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]),
    .ovf_o(ovf[0]), .done_o(done[0]), .state_o(state[0]));

  perf_event_counter #(.NUM_EVENTS(NE), .CNT_WIDTH(W), .SATURATE(1'b0), .CYCLE_LIMIT(0), .SEL_W(4)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .event_i(ev), .clear_i(clear), .freeze_i(freeze),
    .rd_req_i(rd_req), .rd_sel_i(sel), .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]),
    .ovf_o(ovf[1]), .done_o(done[1]), .state_o(state[1]));

  perf_event_counter #(.NUM_EVENTS(NE), .CNT_WIDTH(W), .SATURATE(1'b1), .CYCLE_LIMIT(100), .SEL_W(4)) dut_lim (
    .clk_i(clk), .rst_i(rst), .start_i(start), .event_i(ev), .clear_i(clear), .freeze_i(freeze),
    .rd_req_i(rd_req), .rd_sel_i(sel), .rd_data_o(rd_data[2]), .rd_valid_o(rd_valid[2]),
    .ovf_o(ovf[2]), .done_o(done[2]), .state_o(state[2]));

  // Behavioural model: plain counter arrays per instance.
  bit          sat[3] = '{1'b1, 1'b0, 1'b1};
  int unsigned lim[3] = '{0, 0, 100};
  int unsigned m_cnt[3][NE+1];
  int          m_state[3] = '{0, 0, 0};
  bit [NE:0]   m_ovf[3] = '{5'd0, 5'd0, 5'd0};
  bit          m_done[3] = '{1'b0, 1'b0, 1'b0};
  int unsigned m_rd[3] = '{0, 0, 0};
  bit          m_rv[3] = '{1'b0, 1'b0, 1'b0};

  initial begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j <= NE; j++) m_cnt[i][j] = 0;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void bump(input int i, input int j);
    if (m_cnt[i][j] == MAXV) begin
      m_ovf[i][j] = 1'b1;
      m_cnt[i][j] = sat[i] ? MAXV : 0;
    end else begin
      m_cnt[i][j] = m_cnt[i][j] + 1;
    end
  endfunction

  function automatic void model_edge(input int i);
    if (rst) begin
      for (int j = 0; j <= NE; j++) m_cnt[i][j] = 0;
      m_ovf[i] = '0; m_done[i] = 1'b0; m_state[i] = 0; m_rd[i] = 0; m_rv[i] = 1'b0;
      return;
    end
    m_rv[i] = rd_req;
    if (rd_req) m_rd[i] = (int'(sel) <= NE) ? m_cnt[i][sel] : 0;
    if (clear) begin
      for (int j = 0; j <= NE; j++) m_cnt[i][j] = 0;
      m_ovf[i] = '0; m_done[i] = 1'b0; m_state[i] = 0;
      return;
    end
    if (m_state[i] == 0) begin
      if (start) m_state[i] = 1;
    end else if (m_state[i] == 1) begin
      if (freeze) m_state[i] = 2;
      else if (!start) m_state[i] = 0;
      else begin
        bump(i, 0);
        for (int k = 0; k < NE; k++) if (ev[k]) bump(i, k + 1);
        if (lim[i] != 0 && lim[i] <= MAXV && m_cnt[i][0] == lim[i]) begin
          m_state[i] = 3;
          m_done[i] = 1'b1;
        end
      end
    end else if (m_state[i] == 2) begin
      if (freeze) m_state[i] = start ? 1 : 0;
    end
  endfunction

  // Model advances on every rising edge using the inputs sampled there.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_edge(i);
  end

  // Compare all outputs of every instance against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("rd_data[%0d]", i), rd_data[i], m_rd[i]);
        check($sformatf("rd_valid[%0d]", i), rd_valid[i], m_rv[i]);
        check($sformatf("ovf[%0d]", i), ovf[i], m_ovf[i]);
        check($sformatf("done[%0d]", i), done[i], m_done[i]);
        check($sformatf("state[%0d]", i), state[i], m_state[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_clear();
    clear = 1'b1; start = 1'b0; freeze = 1'b0; rd_req = 1'b0; ev = '0;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_rd_data", rd_data[i], 0);
      check("rst_rd_valid", rd_valid[i], 0);
      check("rst_ovf", ovf[i], 0);
      check("rst_done", done[i], 0);
      check("rst_state", state[i], 0);
    end

    // Ten cycles of start with event 0: first edge is only IDLE->RUN
    start = 1'b1; ev = 4'b0001;
    repeat (10) tick();
    start = 1'b0; ev = '0; rd_req = 1'b1; sel = 4'd0;
    tick();
    check("t1_cyc", rd_data[0], 9);
    check("t1_valid", rd_valid[0], 1);
    sel = 4'd1;
    tick();
    check("t1_ev0", rd_data[0], 9);
    check("t1_ovf", ovf[0], 0);
    rd_req = 1'b0;

    // Cycle limit 100, event 0 on every third counting cycle
    do_clear();
    start = 1'b1; ev = '0;
    tick();
    for (int n = 1; n <= 100; n++) begin
      ev = (n % 3 == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    check("t2_done", done[2], 1);
    check("t2_state", state[2], 3);
    ev = 4'b1111;
    repeat (20) tick();
    rd_req = 1'b1; sel = 4'd0;
    tick();
    check("t2_cyc", rd_data[2], 100);
    sel = 4'd1;
    tick();
    check("t2_ev0", rd_data[2], 33);
    check("t2_state_hold", state[2], 3);
    rd_req = 1'b0;

    // Freeze at cyc=5
    do_clear();
    start = 1'b1; ev = '0;
    repeat (6) tick();
    freeze = 1'b1;
    tick();
    check("t3_frozen", state[0], 2);
    freeze = 1'b0; ev = 4'b1111;
    repeat (4) tick();
    freeze = 1'b1; rd_req = 1'b1; sel = 4'd0;
    tick();
    check("t3_cyc_frozen", rd_data[0], 5);
    check("t3_resume", state[0], 1);
    freeze = 1'b0; ev = '0; sel = 4'd1;
    tick();
    check("t3_ev_frozen", rd_data[0], 0);
    sel = 4'd0;
    tick();
    check("t3_cyc_resumed", rd_data[0], 6);
    rd_req = 1'b0;

    // 300 counting cycles of event 1 on 8-bit counters
    do_clear();
    start = 1'b1; ev = 4'b0010;
    repeat (301) tick();
    start = 1'b0; ev = '0; rd_req = 1'b1; sel = 4'd2;
    tick();
    check("t4_sat_ev1", rd_data[0], 255);
    check("t4_wrap_ev1", rd_data[1], 44);
    check("t4_sat_ovf", ovf[0], 5'b00101);
    check("t4_wrap_ovf", ovf[1], 5'b00101);
    rd_req = 1'b0;

    // Back-to-back reads while counting
    do_clear();
    start = 1'b1; ev = 4'b0001;
    repeat (4) tick();
    rd_req = 1'b1; sel = 4'd0;
    tick();
    check("t5_r0_valid", rd_valid[1], 1);
    check("t5_r0", rd_data[1], 3);
    sel = 4'd1;
    tick();
    check("t5_r1_valid", rd_valid[1], 1);
    check("t5_r1", rd_data[1], 4);
    sel = 4'd2;
    tick();
    check("t5_r2_valid", rd_valid[1], 1);
    check("t5_r2", rd_data[1], 0);
    sel = 4'd7;
    tick();
    check("t5_r7_valid", rd_valid[1], 1);
    check("t5_r7", rd_data[1], 0);
    rd_req = 1'b0;
    tick();
    check("t5_idle_valid", rd_valid[1], 0);

    // Clear together with a read at cyc=42
    do_clear();
    start = 1'b1; ev = '0;
    repeat (43) tick();
    clear = 1'b1; rd_req = 1'b1; sel = 4'd0;
    tick();
    check("t6_read", rd_data[1], 42);
    check("t6_state", state[1], 0);
    check("t6_ovf", ovf[1], 0);
    clear = 1'b0; start = 1'b0;
    tick();
    check("t6_cyc_cleared", rd_data[1], 0);
    rd_req = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 199) == 0);
      clear  = ($urandom_range(0, 49) == 0);
      freeze = ($urandom_range(0, 15) == 0);
      if (m_state[0] == 0 || m_state[1] == 0 || m_state[2] == 0) freeze = 1'b0;
      start  = ($urandom_range(0, 99) < 85);
      ev     = NE'($urandom);
      rd_req = $urandom_range(0, 1) == 1;
      sel    = 4'($urandom);
      tick();
    end
    rst = 1'b0; clear = 1'b0; freeze = 1'b0; rd_req = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
